// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package inst_fetch_pkg;

    localparam int unsigned ADDR_WIDTH  = 16;
    localparam int unsigned DATA_WIDTH  = 16;
    localparam int unsigned CNT_WIDTH   = 16;
    localparam int unsigned MEM_WORDS   = 26;
    localparam int unsigned ENTRY_WIDTH = ADDR_WIDTH + DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] HALT_WORD = 16'hEFFF;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        HALT_WAIT = 2'd1,
        HALT      = 2'd2,
        FAULT     = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

    // Misaligned or beyond the last instruction word.
    function automatic logic pc_bad(input logic [ADDR_WIDTH-1:0] pc);
        return pc[0] | (pc[ADDR_WIDTH-1:1] >= (ADDR_WIDTH-1)'(MEM_WORDS));
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry registered FIFO between fetch and decode; head is always entry 0.
module fetch_queue
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head,
    output logic         o_valid
);

    logic [1:0]   r_count;
    fetch_entry_t r_head;
    fetch_entry_t r_tail;

    // Shift-style storage: a pop moves the tail into the head slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_entry;
                    else                 r_tail <= i_entry;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_entry;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_head;
    assign o_valid = (r_count != 2'd0);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, halt/fault FSM and fetch counter,
// and feeds decode through a two-entry queue.
module inst_fetch_ctrl
    import inst_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redir_valid,
    input  logic [ADDR_WIDTH-1:0] redir_target,
    input  logic                  dec_ready,
    output logic                  dec_valid,
    output logic [DATA_WIDTH-1:0] dec_inst,
    output logic [ADDR_WIDTH-1:0] dec_pc,
    output logic                  halted,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] fault_pc,
    output logic [CNT_WIDTH-1:0]  fetch_cnt
);

    fetch_state_e          r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_nxt;
    logic                  r_halted, w_halted_nxt;
    logic                  r_fault, w_fault_nxt;
    logic [ADDR_WIDTH-1:0] r_fault_pc, w_fault_pc_nxt;
    logic [CNT_WIDTH-1:0]  r_fetch_cnt, w_fetch_cnt_nxt;

    logic         w_push, w_flush, w_pop, w_push_ok, w_q_valid;
    logic [1:0]   w_q_count;
    fetch_entry_t w_q_head, w_new_entry;

    assign w_pop       = w_q_valid & dec_ready;
    assign w_push_ok   = (w_q_count < 2'd2) | w_pop;
    assign w_new_entry = '{pc: r_fetch_pc, inst: imem_data};

    fetch_queue u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_entry (w_new_entry),
        .o_count (w_q_count),
        .o_head  (w_q_head),
        .o_valid (w_q_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= FETCH;
            r_fetch_pc  <= '0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
            r_fault_pc  <= '0;
            r_fetch_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_halted    <= w_halted_nxt;
            r_fault     <= w_fault_nxt;
            r_fault_pc  <= w_fault_pc_nxt;
            r_fetch_cnt <= w_fetch_cnt_nxt;
        end
    end

    // Redirect wins over everything except a latched fault.
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_halted_nxt    = r_halted;
        w_fault_nxt     = r_fault;
        w_fault_pc_nxt  = r_fault_pc;
        w_fetch_cnt_nxt = r_fetch_cnt;
        w_push          = 1'b0;
        w_flush         = 1'b0;

        if (redir_valid && (r_state != FAULT)) begin
            w_flush        = 1'b1;
            w_fetch_pc_nxt = redir_target;
            w_halted_nxt   = 1'b0;
            w_state_nxt    = FETCH;
        end else begin
            case (r_state)
                FETCH: begin
                    if (pc_bad(r_fetch_pc)) begin
                        w_state_nxt    = FAULT;
                        w_fault_nxt    = 1'b1;
                        w_fault_pc_nxt = r_fetch_pc;
                    end else if (w_push_ok) begin
                        w_push         = 1'b1;
                        w_fetch_pc_nxt = r_fetch_pc + ADDR_WIDTH'(2);
                        if (r_fetch_cnt != {CNT_WIDTH{1'b1}})
                            w_fetch_cnt_nxt = r_fetch_cnt + CNT_WIDTH'(1);
                        if (imem_data == HALT_WORD)
                            w_state_nxt = HALT_WAIT;
                    end
                end
                HALT_WAIT: begin
                    // Only the halt word can be popped with that encoding here.
                    if (w_pop && (w_q_head.inst == HALT_WORD)) begin
                        w_state_nxt  = HALT;
                        w_halted_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_fetch_pc;
    assign dec_valid = w_q_valid;
    assign dec_inst  = w_q_head.inst;
    assign dec_pc    = w_q_head.pc;
    assign halted    = r_halted;
    assign fault     = r_fault;
    assign fault_pc  = r_fault_pc;
    assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: stimulus queues expected decode
// entries, a negedge monitor checks every accepted handshake.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redir_valid;
    logic [15:0] redir_target;
    logic        dec_ready;
    logic        dec_valid;
    logic [15:0] dec_inst;
    logic [15:0] dec_pc;
    logic        halted;
    logic        fault;
    logic [15:0] fault_pc;
    logic [15:0] fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    inst_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .dec_ready    (dec_ready),
        .dec_valid    (dec_valid),
        .dec_inst     (dec_inst),
        .dec_pc       (dec_pc),
        .halted       (halted),
        .fault        (fault),
        .fault_pc     (fault_pc),
        .fetch_cnt    (fetch_cnt)
    );

    // Instruction memory: 25 ordinary words then the halt word at 0x32.
    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        int idx;
        idx = int'(addr[15:1]);
        if (idx > 25)  return 16'h0000;
        if (idx == 25) return 16'hEFFF;
        return 16'h1000 + 16'(idx);
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input logic [15:0] pc);
        sb.push_back({pc, mem_word(pc)});
    endtask

    task automatic check_sb_empty(input string name);
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        redir_valid  = 1'b0;
        redir_target = 16'h0000;
        dec_ready    = 1'b0;
        tick();
        tick();
    endtask

    // Monitor: every accepted entry must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && dec_valid === 1'b1 && dec_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", {dec_pc, dec_inst}, 32'hDEAD_DEAD);
            end else begin
                check("dec_entry", {dec_pc, dec_inst}, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_outputs", {halted, fault, fault_pc, fetch_cnt}, 32'd0);
        check("rst_dec_head", {dec_pc, dec_inst}, 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);

        // Straight-line stream at full rate
        for (int i = 0; i < 9; i++) expect_pc(16'(2 * i));
        rst = 1'b1;
        dec_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        dec_ready = 1'b0;
        check("stream_fetch_cnt", 32'(fetch_cnt), 32'd10);
        check("stream_imem_addr", 32'(imem_addr), 32'h14);
        check_sb_empty("stream_drained");

        // Backpressure: queue fills, PC holds, nothing lost on release
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("bp_imem_hold", 32'(imem_addr), 32'h04);
        check("bp_head", {15'd0, dec_valid, dec_pc}, {15'd0, 1'b1, 16'h0000});
        check("bp_fetch_cnt", 32'(fetch_cnt), 32'd2);
        for (int i = 0; i < 4; i++) expect_pc(16'(2 * i));
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        dec_ready = 1'b0;
        check_sb_empty("bp_drained");

        // Redirect with a full queue
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        redir_valid  = 1'b1;
        redir_target = 16'h0024;
        tick();
        redir_valid = 1'b0;
        check("redir_flush_valid", 32'(dec_valid), 32'd0);
        check("redir_imem_addr", 32'(imem_addr), 32'h24);
        expect_pc(16'h0024);
        expect_pc(16'h0026);
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        dec_ready = 1'b0;
        check_sb_empty("redir_drained");

        // Run into the halt word, then redirect out of halt
        do_reset();
        for (int i = 0; i < 26; i++) expect_pc(16'(2 * i));
        rst = 1'b1;
        dec_ready = 1'b1;
        for (int i = 0; i < 26; i++) tick();
        check("halt_wait_pc", 32'(imem_addr), 32'h34);
        check("halt_wait_halted", 32'(halted), 32'd0);
        tick();
        check("halt_set", 32'(halted), 32'd1);
        check("halt_queue_empty", 32'(dec_valid), 32'd0);
        tick();
        tick();
        check("halt_no_fetch", 32'(imem_addr), 32'h34);
        check("halt_fetch_cnt", 32'(fetch_cnt), 32'd26);
        check_sb_empty("halt_drained");
        redir_valid  = 1'b1;
        redir_target = 16'h0000;
        tick();
        redir_valid = 1'b0;
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_imem_addr", 32'(imem_addr), 32'h00);
        expect_pc(16'h0000);
        expect_pc(16'h0002);
        for (int i = 0; i < 3; i++) tick();
        dec_ready = 1'b0;
        check_sb_empty("unhalt_drained");

        // Misaligned redirect faults; later redirects are ignored
        do_reset();
        rst          = 1'b1;
        redir_valid  = 1'b1;
        redir_target = 16'h0033;
        tick();
        redir_valid = 1'b0;
        check("fault_not_yet", 32'(fault), 32'd0);
        tick();
        check("fault_set", {15'd0, fault, fault_pc}, {15'd0, 1'b1, 16'h0033});
        redir_valid  = 1'b1;
        redir_target = 16'h0034;
        tick();
        redir_valid = 1'b0;
        check("fault_redir_ignored", {15'd0, fault, imem_addr}, {15'd0, 1'b1, 16'h0033});
        rst = 1'b0;
        tick();
        check("fault_cleared", {15'd0, fault, fault_pc}, 32'd0);

        // Reset beats a redirect and a handshake in the same cycle
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("pre_reset_full", 32'(dec_valid), 32'd1);
        rst          = 1'b0;
        redir_valid  = 1'b1;
        redir_target = 16'h0024;
        dec_ready    = 1'b1;
        tick();
        redir_valid = 1'b0;
        dec_ready   = 1'b0;
        check("rst_win_valid", {31'd0, dec_valid}, 32'd0);
        check("rst_win_outputs", {halted, fault, fault_pc, fetch_cnt}, 32'd0);
        check("rst_win_head", {dec_pc, dec_inst}, 32'd0);
        check("rst_win_imem_addr", 32'(imem_addr), 32'd0);
        check_sb_empty("final_sb");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Fetch sequencer for the 16-bit CPU's instruction memory. Owns the fetch PC, drives the memory address, and buffers fetched words in a 2-entry queue toward decode with a valid/ready handshake. Handles branch redirects, halt-word detection and fetch faults. Sits between inst_memory (combinational read) and the decode stage.

Parameters:
ADDR_WIDTH, 16, fetch/PC address width (byte address)
DATA_WIDTH, 16, instruction width
MEM_WORDS, 26, number of valid instruction words; valid byte addresses are 0 .. 2*MEM_WORDS-2
HALT_WORD, 16'hEFFF, instruction encoding that terminates fetch

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset: synchronous, active-low
imem_addr  out  ADDR_WIDTH  byte address to instruction memory, equal to fetch_pc
imem_data  in  DATA_WIDTH  instruction word, valid in the same cycle as imem_addr
redir_valid  in  1  branch/jump redirect request, single-cycle pulse
redir_target  in  ADDR_WIDTH  redirect byte address
dec_ready  in  1  decode accepts the head entry this cycle
dec_valid  out  1  head entry valid
dec_inst  out  DATA_WIDTH  head instruction
dec_pc  out  ADDR_WIDTH  byte address of the head instruction
halted  out  1  HALT_WORD consumed by decode; fetch stopped
fault  out  1  fetch fault latched
fault_pc  out  ADDR_WIDTH  faulting address
fetch_cnt  out  16  instructions pushed since reset, saturates at 16'hFFFF

Behaviour:
- Reset (rst==0 at a clock edge): fetch_pc=0, queue emptied, state=FETCH. dec_valid, halted and fault are 0; fault_pc, fetch_cnt, dec_inst and dec_pc are 0. Reset overrides every other input, including mid-redirect and mid-handshake.
- States: FETCH, HALT_WAIT, HALT, FAULT.
- pop = dec_valid & dec_ready. push_ok = (count<2) | pop.
- FETCH, no redirect:
  - If fetch_pc[0]==1 or fetch_pc/2 >= MEM_WORDS: go to FAULT, set fault=1, fault_pc=fetch_pc, no push.
  - Else, if push_ok: push {fetch_pc, imem_data}, fetch_pc += 2, increment fetch_cnt. If imem_data==HALT_WORD, go to HALT_WAIT; fetch_pc still advances.
  - Else (queue full, no pop): hold fetch_pc.
- HALT_WAIT: no fetch. When the HALT_WORD entry is popped, go to HALT and set halted=1 in the following cycle.
- HALT: no fetch; halted stays 1.
- FAULT: no fetch, no push. The queue still drains to decode. fault stays 1 until reset.
- Redirect (redir_valid=1, in FETCH, HALT_WAIT or HALT):
  - Highest priority. The queue flushes this cycle; a simultaneous pop is acknowledged but the entry is discarded. No push this cycle.
  - fetch_pc=redir_target, halted=0, state=FETCH.
  - A misaligned or out-of-range target faults in the next cycle through the normal FETCH check.
  - In FAULT, redirect is ignored.
- Latency: a word fetched in cycle N appears on dec_* in cycle N+1 (registered queue). After reset is released, the first dec_valid is one cycle later, with dec_pc=0.
- Throughput: 1 instruction/cycle sustained when dec_ready is held at 1.
- Queue order is FIFO. dec_inst/dec_pc are stable while dec_valid=1 and dec_ready=0.
- fetch_pc wrap: PC increment is modulo 2^ADDR_WIDTH, but the range check faults before any wrap occurs.
- imem_addr is registered-PC driven: no combinational path from any input to imem_addr.

Decomposition:
- Package inst_fetch_pkg: state encoding (FETCH=2'd0, HALT_WAIT=2'd1, HALT=2'd2, FAULT=2'd3), HALT_WORD constant, queue entry width (ADDR_WIDTH+DATA_WIDTH).
- Sub-module fetch_queue: 2-entry FIFO with push, pop, flush, count and head outputs, and synchronous active-low rst.
- inst_fetch_ctrl keeps the PC, the FSM, the fault logic and fetch_cnt.

Test Plan:
- Reset then dec_ready=1 with a memory model holding 26 words -> dec_pc sequence 0x00, 0x02, 0x04… one per cycle, starting 1 cycle after rst rises; fetch_cnt increments each cycle.
- dec_ready=0 for 4 cycles from pc 0 -> queue holds 0x00 and 0x02, imem_addr holds at 0x04, dec_pc stays 0x00; on release, 0x00, 0x02, 0x04 arrive on consecutive cycles with none lost.
- Full queue plus redir_valid with target 0x24 -> next cycle dec_valid=0 and imem_addr=0x24; the cycle after that, dec_pc=0x24 and dec_inst=mem[18].
- Straight-line run to address 0x32 (16'hEFFF) -> no imem fetch advance after the push of 0x32; halted=1 one cycle after the 0x32 entry is popped; a redirect to 0x00 clears halted and resumes fetch.
- Redirect to 0x33 -> fault=1 and fault_pc=0x0033 one cycle later; a redirect to 0x34 is ignored once faulted; reset clears fault.
- Reset asserted with 2 entries queued and a redirect pulse in the same cycle -> next cycle all outputs are at reset values and imem_addr=0.
